// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command path: command word layout and MODE encodings.
package spi_pkg;

  localparam int CMD_W    = 15;
  localparam int DATA_MSB = 14;
  localparam int DATA_LSB = 7;
  localparam int ADDR_MSB = 6;
  localparam int ADDR_LSB = 2;
  localparam int MODE_MSB = 1;
  localparam int MODE_LSB = 0;

  typedef enum logic [1:0] {
    MODE_RD     = 2'b00,
    MODE_RD_INC = 2'b01,
    MODE_WR     = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  function automatic logic is_rsvd_mode(input logic [1:0] mode);
    return mode == MODE_RSVD;
  endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Synchronous FIFO storage with pointers and occupancy; also reports what the head
// will be after this cycle's push/pop so the parent can register it.
module spi_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [W-1:0]  wr_data_i,
  output logic [CW-1:0] count_o,
  output logic          nonempty_nxt_o,
  output logic [W-1:0]  head_nxt_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Write-through when the entry being pushed is the one that becomes head.
  always_comb begin
    head_nxt_o = mem_q[rd_ptr_d];
    if (push_i && !flush_i && (wr_ptr_q == rd_ptr_d)) head_nxt_o = wr_data_i;
  end

  assign nonempty_nxt_o = (count_d != '0);
  assign count_o        = count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/spi_cmd_queue.sv
// Command queue in front of spi_master: FIFO plus registered head, reserved-mode
// filtering and sticky overflow / bad-mode flags.
module spi_cmd_queue #(
  parameter int DEPTH = 8,
  parameter int CMD_W = spi_pkg::CMD_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CMD_W-1:0]       s_cmd,
  input  logic                   s_cs_sel,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [CMD_W-1:0]       m_cmd,
  output logic                   m_cs_sel,
  output logic                   m_valid,
  input  logic                   m_ready,
  input  logic                   flush,
  input  logic                   clr_err,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   ovf,
  output logic                   bad_mode
);
  import spi_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]    fifo_count;
  logic             nonempty_nxt;
  logic [CMD_W:0]   head_nxt;
  logic             accept, push_st, pop;
  logic             m_valid_q, m_valid_d;
  logic [CMD_W-1:0] m_cmd_q, m_cmd_d;
  logic             m_cs_q, m_cs_d;
  logic             ovf_q, ovf_d;
  logic             bad_q, bad_d;

  spi_sync_fifo #(.DEPTH(DEPTH), .W(CMD_W + 1)) u_fifo (
    .clk            (clk),
    .rst            (rst),
    .push_i         (push_st),
    .pop_i          (pop),
    .flush_i        (flush),
    .wr_data_i      ({s_cs_sel, s_cmd}),
    .count_o        (fifo_count),
    .nonempty_nxt_o (nonempty_nxt),
    .head_nxt_o     (head_nxt)
  );

  assign full    = (fifo_count == CW'(DEPTH));
  assign empty   = (fifo_count == '0);
  assign count   = fifo_count;
  assign s_ready = rst & ~full;
  assign accept  = s_valid & s_ready;
  assign push_st = accept & ~flush & ~is_rsvd_mode(s_cmd[MODE_MSB:MODE_LSB]);
  assign pop     = m_valid_q & m_ready;

  // Head register mirrors the FIFO head; it holds its last value once the queue empties.
  always_comb begin
    m_valid_d = nonempty_nxt;
    m_cmd_d   = m_cmd_q;
    m_cs_d    = m_cs_q;
    if (nonempty_nxt) begin
      m_cmd_d = head_nxt[CMD_W-1:0];
      m_cs_d  = head_nxt[CMD_W];
    end
    ovf_d = (s_valid & ~s_ready & ~flush) | (ovf_q & ~clr_err);
    bad_d = (accept & is_rsvd_mode(s_cmd[MODE_MSB:MODE_LSB])) | (bad_q & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      m_valid_q <= 1'b0;
      m_cmd_q   <= '0;
      m_cs_q    <= 1'b1;
      ovf_q     <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      m_valid_q <= m_valid_d;
      m_cmd_q   <= m_cmd_d;
      m_cs_q    <= m_cs_d;
      ovf_q     <= ovf_d;
      bad_q     <= bad_d;
    end
  end

  assign m_valid  = m_valid_q;
  assign m_cmd    = m_cmd_q;
  assign m_cs_sel = m_cs_q;
  assign ovf      = ovf_q;
  assign bad_mode = bad_q;

endmodule
